// File: rtl/jtag_bscan_top_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bscan_top_pkg
// Brief    : Shared TAP state encoding, IR opcodes and BSR cell indexing
//            for the boundary-scan chip top.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_bscan_top_pkg;

  localparam int IR_W = 2;

  typedef logic [IR_W-1:0] ir_t;

  // Sixteen TAP controller states
  typedef enum logic [3:0] {
    TAP_TLR        = 4'h0,
    TAP_RTI        = 4'h1,
    TAP_SELECT_DR  = 4'h2,
    TAP_CAPTURE_DR = 4'h3,
    TAP_SHIFT_DR   = 4'h4,
    TAP_EXIT1_DR   = 4'h5,
    TAP_PAUSE_DR   = 4'h6,
    TAP_EXIT2_DR   = 4'h7,
    TAP_UPDATE_DR  = 4'h8,
    TAP_SELECT_IR  = 4'h9,
    TAP_CAPTURE_IR = 4'hA,
    TAP_SHIFT_IR   = 4'hB,
    TAP_EXIT1_IR   = 4'hC,
    TAP_PAUSE_IR   = 4'hD,
    TAP_EXIT2_IR   = 4'hE,
    TAP_UPDATE_IR  = 4'hF
  } tap_state_e;

  // Instruction opcodes
  localparam ir_t c_ir_extest  = 2'b00;
  localparam ir_t c_ir_sample  = 2'b01;
  localparam ir_t c_ir_intest  = 2'b10;
  localparam ir_t c_ir_bypass  = 2'b11;
  // Fixed value loaded into the IR shift stage on Capture-IR
  localparam ir_t c_ir_capture = 2'b01;

  // BSR cell positions, TDI side is index 0
  localparam int c_idx_a = 0;

  function automatic int idx_b(input int n);
    return n;
  endfunction

  function automatic int idx_cin(input int n);
    return 2 * n;
  endfunction

  function automatic int idx_sel(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int idx_sum(input int n);
    return 2 * n + 2;
  endfunction

  function automatic int idx_co(input int n);
    return 3 * n + 2;
  endfunction

  function automatic int bsr_len(input int n);
    return 3 * n + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_bscan_top_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bscan_top_if
// Brief    : Chip pin bundle: JTAG serial pins plus the adder/subtractor
//            system pins. master = board side, slave = chip side.
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_bscan_top_if #(
  parameter int N = 16
);
  logic         TMS;
  logic         TDI;
  logic         TDO;
  logic [N-1:0] sys_pin_a;
  logic [N-1:0] sys_pin_b;
  logic         sys_pin_cin;
  logic         sys_pin_sel;
  logic [N-1:0] sys_pin_sum;
  logic         sys_pin_co;

  modport master (
    output TMS, TDI, sys_pin_a, sys_pin_b, sys_pin_cin, sys_pin_sel,
    input  TDO, sys_pin_sum, sys_pin_co
  );

  modport slave (
    input  TMS, TDI, sys_pin_a, sys_pin_b, sys_pin_cin, sys_pin_sel,
    output TDO, sys_pin_sum, sys_pin_co
  );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_fsm
// Brief    : 16-state TAP controller with decoded capture/shift/update
//            strobes and a register-reset strobe for Test-Logic-Reset.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
  import jtag_bscan_top_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_tms,
  output logic o_capture_dr,
  output logic o_shift_dr,
  output logic o_update_dr,
  output logic o_capture_ir,
  output logic o_shift_ir,
  output logic o_update_ir,
  output logic o_regs_reset
);

  tap_state_e r_state;
  tap_state_e w_state_next;

  // TAP state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= TAP_TLR;
    else     r_state <= w_state_next;
  end

  // Next-state decode and per-state action strobes
  always_comb begin
    w_state_next = r_state;
    o_capture_dr = 1'b0;
    o_shift_dr   = 1'b0;
    o_update_dr  = 1'b0;
    o_capture_ir = 1'b0;
    o_shift_ir   = 1'b0;
    o_update_ir  = 1'b0;
    case (r_state)
      TAP_TLR:        w_state_next = i_tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:        w_state_next = i_tms ? TAP_SELECT_DR : TAP_RTI;
      TAP_SELECT_DR:  w_state_next = i_tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: begin
        o_capture_dr = 1'b1;
        w_state_next = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      end
      TAP_SHIFT_DR: begin
        o_shift_dr   = 1'b1;
        w_state_next = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      end
      TAP_EXIT1_DR:   w_state_next = i_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   w_state_next = i_tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   w_state_next = i_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR: begin
        o_update_dr  = 1'b1;
        w_state_next = i_tms ? TAP_SELECT_DR : TAP_RTI;
      end
      TAP_SELECT_IR:  w_state_next = i_tms ? TAP_TLR : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: begin
        o_capture_ir = 1'b1;
        w_state_next = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      end
      TAP_SHIFT_IR: begin
        o_shift_ir   = 1'b1;
        w_state_next = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      end
      TAP_EXIT1_IR:   w_state_next = i_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   w_state_next = i_tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   w_state_next = i_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR: begin
        o_update_ir  = 1'b1;
        w_state_next = i_tms ? TAP_SELECT_DR : TAP_RTI;
      end
      default:        w_state_next = TAP_TLR;
    endcase
    // Clearing on the edge that enters Test-Logic-Reset makes the reset
    // values visible as soon as the controller arrives there.
    o_regs_reset = rst || (w_state_next == TAP_TLR);
  end

endmodule
`default_nettype wire

// File: rtl/jtag_bscan_top.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bscan_top
// Brief    : Chip top: TAP controller, 2-bit IR, bypass register and a
//            3*N+3 cell boundary-scan register wrapped around an N-bit
//            add/subtract core.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_bscan_top
  import jtag_bscan_top_pkg::*;
#(
  parameter int N = 16
) (
  input  logic             TCK,
  input  logic             TRST,
  jtag_bscan_top_if.slave  bus
);

  localparam int c_bsr_len = bsr_len(N);
  localparam int c_idx_b   = idx_b(N);
  localparam int c_idx_cin = idx_cin(N);
  localparam int c_idx_sel = idx_sel(N);
  localparam int c_idx_sum = idx_sum(N);
  localparam int c_idx_co  = idx_co(N);

  logic w_capture_dr, w_shift_dr, w_update_dr;
  logic w_capture_ir, w_shift_ir, w_update_ir;
  logic w_regs_reset;

  ir_t  r_ir_sh, r_ir_upd, w_ir_shin;
  logic w_extest, w_intest, w_sel_bsr;

  logic [c_bsr_len-1:0] r_bsr_sh, r_bsr_upd, w_bsr_cap, w_bsr_shin;
  logic r_bypass, r_tdo, w_tdo_next;

  logic [N-1:0] w_core_a, w_core_b, w_b_eff, w_core_sum, w_pin_sum;
  logic         w_core_cin, w_core_sel, w_core_co, w_pin_co;
  logic [N:0]   w_core_res;

  jtag_tap_fsm u_fsm (
    .clk          (TCK),
    .rst          (TRST),
    .i_tms        (bus.TMS),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_update_dr),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir),
    .o_regs_reset (w_regs_reset)
  );

  assign w_extest  = (r_ir_upd == c_ir_extest);
  assign w_intest  = (r_ir_upd == c_ir_intest);
  assign w_sel_bsr = w_extest || w_intest || (r_ir_upd == c_ir_sample);

  // ---------------- Instruction register ----------------
  // TDI enters at the MSB, LSB leaves toward TDO
  assign w_ir_shin = {bus.TDI, r_ir_sh[IR_W-1:1]};

  for (genvar j = 0; j < IR_W; j++) begin : g_ir_bit
    // IR shift stage and update latch for one bit
    always_ff @(posedge TCK) begin
      if (w_regs_reset) begin
        r_ir_sh[j]  <= c_ir_capture[j];
        r_ir_upd[j] <= c_ir_bypass[j];
      end else begin
        if (w_capture_ir)    r_ir_sh[j] <= c_ir_capture[j];
        else if (w_shift_ir) r_ir_sh[j] <= w_ir_shin[j];
        if (w_update_ir)     r_ir_upd[j] <= r_ir_sh[j];
      end
    end
  end

  // ---------------- Core input muxing ----------------
  for (genvar i = 0; i < N; i++) begin : g_core_in
    assign w_core_a[i] = w_intest ? r_bsr_upd[c_idx_a + i] : bus.sys_pin_a[i];
    assign w_core_b[i] = w_intest ? r_bsr_upd[c_idx_b + i] : bus.sys_pin_b[i];
  end
  assign w_core_cin = w_intest ? r_bsr_upd[c_idx_cin] : bus.sys_pin_cin;
  assign w_core_sel = w_intest ? r_bsr_upd[c_idx_sel] : bus.sys_pin_sel;

  // Add (sel=1) or add-with-inverted-B (sel=0), full N+1 bit result
  always_comb begin
    w_b_eff    = w_core_sel ? w_core_b : ~w_core_b;
    w_core_res = {1'b0, w_core_a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_core_cin};
  end
  assign {w_core_co, w_core_sum} = w_core_res;

  // ---------------- Output pin muxing ----------------
  for (genvar i = 0; i < N; i++) begin : g_pin_out
    assign w_pin_sum[i] = (w_extest || w_intest) ? r_bsr_upd[c_idx_sum + i]
                                                 : w_core_sum[i];
  end
  assign w_pin_co        = (w_extest || w_intest) ? r_bsr_upd[c_idx_co] : w_core_co;
  assign bus.sys_pin_sum = w_pin_sum;
  assign bus.sys_pin_co  = w_pin_co;

  // ---------------- Boundary-scan register ----------------
  // Input cells see the pins, output cells see the core result
  assign w_bsr_cap  = {w_core_co, w_core_sum, bus.sys_pin_sel, bus.sys_pin_cin,
                       bus.sys_pin_b, bus.sys_pin_a};
  assign w_bsr_shin = {r_bsr_sh[c_bsr_len-2:0], bus.TDI};

  for (genvar i = 0; i < c_bsr_len; i++) begin : g_bsr_cell
    // One BSR cell: capture/shift flop plus update latch
    always_ff @(posedge TCK) begin
      if (w_regs_reset) begin
        r_bsr_sh[i]  <= 1'b0;
        r_bsr_upd[i] <= 1'b0;
      end else begin
        if (w_capture_dr && w_sel_bsr)    r_bsr_sh[i] <= w_bsr_cap[i];
        else if (w_shift_dr && w_sel_bsr) r_bsr_sh[i] <= w_bsr_shin[i];
        if (w_update_dr && w_sel_bsr)     r_bsr_upd[i] <= r_bsr_sh[i];
      end
    end
  end

  // ---------------- Bypass register ----------------
  // Single-bit DR used when no boundary instruction is active
  always_ff @(posedge TCK) begin
    if (w_regs_reset)                    r_bypass <= 1'b0;
    else if (w_capture_dr && !w_sel_bsr) r_bypass <= 1'b0;
    else if (w_shift_dr && !w_sel_bsr)   r_bypass <= bus.TDI;
  end

  // ---------------- TDO ----------------
  // Serial output source for the current shift state
  always_comb begin
    w_tdo_next = 1'b0;
    if (w_shift_ir)      w_tdo_next = r_ir_sh[0];
    else if (w_shift_dr) w_tdo_next = w_sel_bsr ? r_bsr_sh[c_bsr_len-1] : r_bypass;
  end

  // TDO is launched on the falling edge so it is stable at the next rising edge
  always_ff @(negedge TCK) begin
    if (TRST) r_tdo <= 1'b0;
    else      r_tdo <= w_tdo_next;
  end
  assign bus.TDO = r_tdo;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bscan_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_bscan_top
// Brief    : Directed bench for jtag_bscan_top with an abstract chip model
//            checked every TCK, plus hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_bscan_top;

  localparam int S_TLR = 0,  S_RTI = 1,  S_SELDR = 2,  S_CAPDR = 3,
                 S_SHDR = 4, S_EX1DR = 5, S_PDR = 6,   S_EX2DR = 7,
                 S_UPDDR = 8, S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11,
                 S_EX1IR = 12, S_PIR = 13, S_EX2IR = 14, S_UPDIR = 15;

  logic tck = 1'b0;
  logic trst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  jtag_bscan_top_if #(.N(16)) bus ();

  jtag_bscan_top #(.N(16)) dut (
    .TCK  (tck),
    .TRST (trst),
    .bus  (bus.slave)
  );

  always #5 tck = ~tck;

  // ---------------- Abstract model ----------------
  int          m_st   = S_TLR;
  logic [1:0]  m_ir   = 2'b11;
  logic [1:0]  m_irsh = 2'b01;
  logic        m_byp  = 1'b0;
  logic [50:0] m_bsr  = '0;
  logic [50:0] m_lat  = '0;

  // IEEE 1149.1 TAP transition table
  function automatic int tap_next(input int s, input logic tms);
    case (s)
      S_TLR:   return tms ? S_TLR   : S_RTI;
      S_RTI:   return tms ? S_SELDR : S_RTI;
      S_SELDR: return tms ? S_SELIR : S_CAPDR;
      S_CAPDR: return tms ? S_EX1DR : S_SHDR;
      S_SHDR:  return tms ? S_EX1DR : S_SHDR;
      S_EX1DR: return tms ? S_UPDDR : S_PDR;
      S_PDR:   return tms ? S_EX2DR : S_PDR;
      S_EX2DR: return tms ? S_UPDDR : S_SHDR;
      S_UPDDR: return tms ? S_SELDR : S_RTI;
      S_SELIR: return tms ? S_TLR   : S_CAPIR;
      S_CAPIR: return tms ? S_EX1IR : S_SHIR;
      S_SHIR:  return tms ? S_EX1IR : S_SHIR;
      S_EX1IR: return tms ? S_UPDIR : S_PIR;
      S_PIR:   return tms ? S_EX2IR : S_PIR;
      S_EX2IR: return tms ? S_UPDIR : S_SHIR;
      default: return tms ? S_SELDR : S_RTI;
    endcase
  endfunction

  function automatic logic [16:0] core_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sel);
    int unsigned r;
    if (sel) r = 32'(a) + 32'(b) + 32'(cin);
    else     r = 32'(a) + (32'd65535 - 32'(b)) + 32'(cin);
    return r[16:0];
  endfunction

  // Core result as the chip currently sees its inputs
  function automatic logic [16:0] core_now();
    if (m_ir == 2'b10)
      return core_ref(m_lat[15:0], m_lat[31:16], m_lat[32], m_lat[33]);
    return core_ref(bus.sys_pin_a, bus.sys_pin_b, bus.sys_pin_cin, bus.sys_pin_sel);
  endfunction

  function automatic logic [16:0] exp_pins();
    if (m_ir == 2'b00 || m_ir == 2'b10) return m_lat[50:34];
    return core_now();
  endfunction

  function automatic logic exp_tdo();
    if (trst) return 1'b0;
    if (m_st == S_SHIR) return m_irsh[0];
    if (m_st == S_SHDR) return (m_ir == 2'b11) ? m_byp : m_bsr[50];
    return 1'b0;
  endfunction

  task automatic mdl_clk(input logic tms, input logic tdi);
    int nx;
    logic [16:0] c;
    nx = tap_next(m_st, tms);
    if (trst || nx == S_TLR) begin
      m_ir = 2'b11; m_irsh = 2'b01; m_byp = 1'b0; m_bsr = '0; m_lat = '0;
      m_st = S_TLR;
    end else begin
      case (m_st)
        S_CAPIR: m_irsh = 2'b01;
        S_SHIR:  m_irsh = {tdi, m_irsh[1]};
        S_UPDIR: m_ir = m_irsh;
        S_CAPDR: begin
          c = core_now();
          if (m_ir == 2'b11) m_byp = 1'b0;
          else m_bsr = {c, bus.sys_pin_sel, bus.sys_pin_cin, bus.sys_pin_b, bus.sys_pin_a};
        end
        S_SHDR:  if (m_ir == 2'b11) m_byp = tdi; else m_bsr = {m_bsr[49:0], tdi};
        S_UPDDR: if (m_ir != 2'b11) m_lat = m_bsr;
        default: ;
      endcase
      m_st = nx;
    end
  endtask

  // ---------------- Checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: TDO and result pins against the model
  always begin
    @(negedge tck);
    #2;
    if (chk_en) begin
      check("tdo_vs_model", 64'(bus.TDO), 64'(exp_tdo()));
      check("pins_vs_model", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'(exp_pins()));
    end
  end

  function automatic logic [50:0] rev51(input logic [50:0] v);
    logic [50:0] r;
    for (int k = 0; k < 51; k++) r[k] = v[50-k];
    return r;
  endfunction

  // ---------------- Stimulus helpers ----------------
  task automatic step(input logic tms, input logic tdi, output logic tdo_s);
    bus.TMS = tms;
    bus.TDI = tdi;
    @(negedge tck); #1;
    tdo_s = bus.TDO;
    @(posedge tck); #1;
    mdl_clk(tms, tdi);
  endtask

  task automatic idle();
    logic t;
    step(1'b0, 1'b0, t);
  endtask

  task automatic set_pins(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sel);
    bus.sys_pin_a = a; bus.sys_pin_b = b; bus.sys_pin_cin = cin; bus.sys_pin_sel = sel;
  endtask

  task automatic load_ir(input logic [1:0] v, output logic [1:0] cap);
    logic t;
    step(1'b1, 1'b0, t); step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    step(1'b0, v[0], t); cap[0] = t;
    step(1'b1, v[1], t); cap[1] = t;
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
  endtask

  task automatic scan_dr(input logic [50:0] din, input int len, output logic [50:0] dout);
    logic t;
    dout = '0;
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    for (int k = 0; k < len; k++) begin
      step(logic'(k == len - 1), din[k], t);
      dout[k] = t;
    end
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    logic [1:0]  cap;
    logic [50:0] dout;
    logic        t;
    trst = 1'b1;
    bus.TMS = 1'b1; bus.TDI = 1'b0;
    set_pins(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    @(posedge tck); #1;
    step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    trst = 1'b0;
    chk_en = 1'b1;

    // Functional mode right after reset
    step(1'b0, 1'b0, t);
    check("reset_tdo", 64'(t), 64'd0);
    check("reset_ir_latch", 64'(dut.r_ir_upd), 64'h3);
    check("func_add", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h0FFFF);
    set_pins(16'h0005, 16'h0003, 1'b1, 1'b0);
    idle();
    check("func_sub", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h10002);

    // BYPASS: captured 0 first, then TDI delayed one TCK
    scan_dr(51'h4D, 8, dout);
    check("bypass_stream", 64'(dout[7:0]), 64'h9A);

    // IR scans return the fixed capture value 01
    load_ir(2'b00, cap);
    check("ir_capture_1", 64'(cap), 64'h1);
    load_ir(2'b01, cap);
    check("ir_capture_2", 64'(cap), 64'h1);

    // EXTEST preload through SAMPLE/PRELOAD
    scan_dr(rev51({1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0F0F, 16'h1234}), 51, dout);
    load_ir(2'b00, cap);
    check("extest_pins", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h1A5A5);
    set_pins(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    idle();
    check("extest_pins_hold", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h1A5A5);

    // INTEST: core runs on preloaded a=1234 b=0F0F cin=0 sel=1
    load_ir(2'b10, cap);
    scan_dr('0, 51, dout);
    check("intest_capture", 64'(dout),
          64'(rev51({1'b0, 16'h2143, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF})));

    // Capture, Exit1 with no shift, pause, update: captured data reaches latches
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t); step(1'b0, 1'b0, t); step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    check("exit1_no_shift", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h0FFFF);

    // SAMPLE capture of live pins
    load_ir(2'b01, cap);
    set_pins(16'h1234, 16'h0001, 1'b0, 1'b1);
    idle();
    check("sample_func", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h01235);
    scan_dr('0, 51, dout);
    check("sample_stream", 64'(dout),
          64'(rev51({1'b0, 16'h1235, 1'b1, 1'b0, 16'h0001, 16'h1234})));

    // TRST in the middle of an IR shift
    load_ir(2'b00, cap);
    check("extest_zero_latch", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h0);
    step(1'b1, 1'b0, t); step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    trst = 1'b1;
    step(1'b0, 1'b0, t);
    trst = 1'b0;
    check("trst_mid_ir", 64'(dut.r_ir_upd), 64'h3);
    check("trst_func", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h01235);
    idle();

    // Five TMS=1 edges from inside Shift-DR reach Test-Logic-Reset
    load_ir(2'b10, cap);
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    step(1'b0, 1'b1, t); step(1'b0, 1'b1, t);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, t);
    check("tms_reset_model_state", 64'(m_st), 64'(S_TLR));
    check("tms_reset_ir", 64'(dut.r_ir_upd), 64'h3);
    step(1'b1, 1'b0, t);
    check("tms_reset_tdo", 64'(t), 64'd0);
    check("tms_reset_func", 64'({bus.sys_pin_co, bus.sys_pin_sum}), 64'h01235);
    idle();
    idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
